// File: rtl/median_result_streamer_if.sv
// median_result_streamer_if: filter done level, result RAM read port and pixel stream
// bundled for median_result_streamer (master) and its RAM/consumer side (slave).
interface median_result_streamer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) ();
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              busy;
    logic              stream_done;
    modport master (
        input  done, rd_data, pix_ready,
        output rd_en, rd_addr, pix_data, pix_valid, pix_last, busy, stream_done
    );
    modport slave (
        output done, rd_data, pix_ready,
        input  rd_en, rd_addr, pix_data, pix_valid, pix_last, busy, stream_done
    );
endinterface

// File: rtl/median_result_streamer.sv
// median_result_streamer: streams the result RAM in raster order on valid/ready after done.
// Define STREAMER_BORDER_ZERO_EN to force border pixels to zero on output.
module median_result_streamer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input logic                      clka,
    input logic                      reset,
    median_result_streamer_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, FINISH, REARM} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, infl_q, infl_d;
    logic [DATA_W-1:0] mem_q [2];
    logic              valid, pop, issue, last;

    always_ff @(posedge clka) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            infl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= infl_d;
        end
    end

    always_ff @(posedge clka)
        if (infl_q) mem_q[wr_ptr_q] <= bus.rd_data;

    always_comb begin
        valid    = cnt_q != 2'd0;
        pop      = valid && bus.pix_ready;
        last     = row_q == ROW_MAX && col_q == COL_MAX;
        // Credit the slot freed by this cycle's pop so a full-ready stream never bubbles.
        issue    = state_q == STREAM && (cnt_q + {1'b0, infl_q}) < (2'd2 + {1'b0, pop});
        state_d  = state_q;
        cnt_d    = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ infl_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        infl_d   = issue;
        addr_d   = issue ? addr_q + ADDR_W'(1) : addr_q;
        col_d    = pop ? (col_q == COL_MAX ? '0 : col_q + CW'(1)) : col_q;
        row_d    = (pop && col_q == COL_MAX) ? (row_q == ROW_MAX ? '0 : row_q + RW'(1)) : row_q;
        case (state_q)
            IDLE: if (bus.done) begin
                state_d = STREAM;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
            end
            STREAM:  state_d = (issue && addr_q == LAST_ADDR) ? DRAIN : STREAM;
            DRAIN:   state_d = (pop && last) ? FINISH : DRAIN;
            FINISH:  state_d = REARM;
            REARM:   state_d = bus.done ? REARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_en       = issue;
    assign bus.rd_addr     = addr_q;
    assign bus.pix_valid   = valid;
    assign bus.pix_last    = valid && last;
    assign bus.busy        = state_q == STREAM || state_q == DRAIN;
    assign bus.stream_done = state_q == FINISH;

`ifdef STREAMER_BORDER_ZERO_EN
    logic border;
    assign border       = row_q == '0 || row_q == ROW_MAX || col_q == '0 || col_q == COL_MAX;
    assign bus.pix_data = (valid && !border) ? mem_q[rd_ptr_q] : '0;
`else
    assign bus.pix_data = valid ? mem_q[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_median_result_streamer.sv
// tb_median_result_streamer: 4x3 image, RAM[i]=i+10; raster-order model checked every cycle
// plus literal latency/count expectations; covers throughput, backpressure, re-arm, mid-stream reset.
module tb_median_result_streamer;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk;
    logic reset;
    int   mode;
    int   vectors = 0, errors = 0, cyc = 0;
    int   issued = 0, idx = 0, total_reads = 0, total_hs = 0, pulses = 0;
    int   first_rd = 0, first_hs = 0, last_hs_cyc = 0, pix5 = 0;
    logic last_hs = 1'b0, active = 1'b0, stalled = 1'b0, rst_s = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;
    logic [7:0] ram [16];

    median_result_streamer_if #(.DATA_W(8), .ADDR_W(16)) bus ();

    median_result_streamer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
        .clka (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr[3:0]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int i);
`ifdef STREAMER_BORDER_ZERO_EN
        int r = i / W;
        int c = i % W;
        return (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'd0 : 8'(i + 10);
`else
        return 8'(i + 10);
`endif
    endfunction

    // Raster-order model: pixel k of each stream must be exp_pix(k), once, in order.
    always @(negedge clk) begin
        if (!rst_s) begin
            chk("reset_outputs", 32'({bus.rd_en, bus.rd_addr, bus.pix_data, bus.pix_valid,
                                      bus.pix_last, bus.busy, bus.stream_done}), 0);
            issued  = 0;
            idx     = 0;
            last_hs = 1'b0;
            active  = 1'b0;
            stalled = 1'b0;
        end else begin
            chk("stream_done", 32'(bus.stream_done), 32'(last_hs));
            if (bus.stream_done) pulses++;
            if (last_hs) begin
                issued = 0;
                idx    = 0;
            end
            if (bus.rd_en) begin
                if (issued == 0) begin
                    active   = 1'b1;
                    first_rd = cyc;
                end
                chk("rd_addr", 32'(bus.rd_addr), issued);
                issued++;
                total_reads++;
            end
            chk("busy", 32'(bus.busy), 32'(active));
            if (stalled) begin
                chk("stall_valid", 32'(bus.pix_valid), 1);
                chk("stall_data", 32'(bus.pix_data), 32'(held_data));
                chk("stall_last", 32'(bus.pix_last), 32'(held_last));
            end
            last_hs = 1'b0;
            if (bus.pix_valid && bus.pix_ready) begin
                chk("pix_data", 32'(bus.pix_data), 32'(exp_pix(idx)));
                chk("pix_last", 32'(bus.pix_last), 32'(idx == N - 1));
                if (idx == 0) first_hs = cyc;
                if (idx == 5) pix5 = 32'(bus.pix_data);
                if (idx == N - 1) begin
                    last_hs     = 1'b1;
                    last_hs_cyc = cyc;
                    active      = 1'b0;
                end
                idx++;
                total_hs++;
            end
            chk("outstanding", 32'(issued - idx <= 2), 1);
            stalled   = bus.pix_valid && !bus.pix_ready;
            held_data = bus.pix_data;
            held_last = bus.pix_last;
        end
        rst_s = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.pix_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
    endtask

    task automatic wait_done(input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = bus.stream_done;
        end
        if (!seen) chk("stream_done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 10);
        mode          = 0;
        reset         = 1'b0;
        bus.done      = 1'b1;
        bus.pix_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.pix_valid), 0);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        tick();
        chk("start_rd_en", 32'(bus.rd_en), 1);
        chk("start_rd_addr", 32'(bus.rd_addr), 0);
        wait_done(60);
        chk("pulses_1", pulses, 1);
        chk("hs_total_1", total_hs, 12);
        chk("hs_span", last_hs_cyc - first_hs, 11);
        chk("first_pix_latency", first_hs - first_rd, 2);
        chk("last_hs_latency", last_hs_cyc - first_rd, 13);
        chk("pix5_value", pix5, 15);
        for (int i = 0; i < 20; i++) tick();
        chk("held_done_reads", total_reads, 12);
        chk("held_done_pulses", pulses, 1);
        bus.done = 1'b0;
        tick();
        bus.done = 1'b1;
        mode = 1;
        wait_done(200);
        chk("pulses_2", pulses, 2);
        chk("hs_total_2", total_hs, 24);
        chk("reads_total_2", total_reads, 24);
        mode = 0;
        bus.done = 1'b0;
        tick();
        bus.done = 1'b1;
        for (int i = 0; i < 60 && idx < 6; i++) tick();
        chk("mid_reached_pix5", 32'(idx >= 6), 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.pix_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_rd_en", 32'(bus.rd_en), 0);
        reset = 1'b1;
        tick();
        chk("restart_rd_en", 32'(bus.rd_en), 1);
        chk("restart_rd_addr", 32'(bus.rd_addr), 0);
        wait_done(60);
        chk("pulses_3", pulses, 3);
        chk("pix5_value_3", pix5, 15);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
